regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
//  Shares the single register-file write port between three writeback sources:
//  src0 ALU, src1 load data, src2 I/O bus. Each source has a one-entry holding register.
//  The arbiter picks one pending entry per cycle (round-robin).
//  It drives the 2-bit select of the downstream 3:1 writeback data mux (arg1/arg2/arg3)
//  together with rf_wen and rf_waddr.
//  Same-address writes are kept in order by refusing a request that collides with a pending entry.
// PARAMETERS
//  DW     `DATAWIDTH (16)  data width of holding registers and mux args
//  AW     4                register address width
// PORTS
//  clk        in   1      system clock, rising edge
//  reset      in   1      asynchronous, active-high reset
//  req        in   3      req[i]: source i presents addr_i/data_i this cycle
//  ack        out  3      ack[i]: source i's request accepted at this clk edge
//  addr0..2   in   AW     destination register of source i
//  data0..2   in   DW     write data of source i
//  rf_stall   in   1      register file cannot accept a write this cycle
//  arg1..3    out  DW     holding-register data of src0/src1/src2 -> mux arg1/arg2/arg3
//  mux_sel    out  2      mux select: src0=2'b00, src1=2'b01, src2=2'b10; never 2'b11
//  rf_wen     out  1      register-file write enable
//  rf_waddr   out  AW     address of the entry being written
//  busy       out  1      |hold_valid
// BEHAVIOUR
//  - State: hold_valid[2:0], hold_addr[i], hold_data[i], rr_ptr[1:0] (range 0..2).
//  - Reset (async): hold_valid=0, rr_ptr=0, hold_addr/hold_data=0.
//    Resulting outputs: rf_wen=0, mux_sel=00, rf_waddr=0, ack=0 while reset is high, busy=0, arg*=0.
//    Pending writes are discarded, not completed.
//  - Grant (combinational from registered state):
//    - When rf_stall=0, grant the first valid entry scanning rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3).
//    - When rf_stall=1 or no entry is valid, there is no grant.
//  - Write outputs during a grant cycle: rf_wen=1, mux_sel=enc(g), rf_waddr=hold_addr[g].
//    Otherwise rf_wen=0, mux_sel=00, rf_waddr=0.
//  - drain[i] = granted this cycle. At the clk edge a drained entry clears, and rr_ptr <= (g+1) mod 3.
//    rr_ptr holds when there is no grant.
//  - ack[i] = req[i] & (~hold_valid[i] | drain[i]) & ~conflict[i].
//    conflict[i] = some j!=i with hold_valid[j] & ~drain[j] & hold_addr[j]==addr_i.
//    On ack the entry loads addr_i/data_i and hold_valid[i] <= 1.
//  - Simultaneous drain + accept on the same source: the new entry is loaded and stays valid.
//    This gives back-to-back throughput of 1 per source.
//  - Multiple simultaneous req with the same addr and no pending entry: accept only the lowest index.
//    Higher indices are denied that cycle (prevents unordered WAW).
//  - Latency: a request acked at edge N, with no contention, writes at edge N+1 (rf_wen high in cycle N+1).
//    Worst case is 3 cycles with all sources pending and no stall.
//  - rf_stall freezes grants and rr_ptr. ack is still given to empty, non-conflicting entries.
//  - Sources must hold req/addr/data until ack. Dropping req before ack is legal and leaves no state.
//  - ack is combinational from req/addr and state; there is no combinational path from rf_stall to ack
//    except through drain.
// STRUCTURE
//  - defines.v: add `WB_AW (4), `WB_SEL_SRC0/1/2 (2'b00/01/10), `WB_NSRC (3).
//  - Sub-module rr_pick3: combinational round-robin picker.
//    Inputs: valid[2:0], ptr[1:0], en. Outputs: gnt onehot[2:0], gidx[1:0], any.
//  - Top level contains the holding registers, the conflict compare (6 AW-bit comparators),
//    rr_ptr, and the output decode.
//  - The existing 3:1 writeback mux stays external. The arbiter never drives data onto the register file itself.
// TESTING
//  1. Reset: assert reset mid-cycle with src1 pending -> outputs immediately rf_wen=0, busy=0.
//     After release, no write of src1 occurs.
//  2. Single: req0 addr=3 data=16'hBEEF at edge N -> ack0=1.
//     In cycle N+1: rf_wen=1, mux_sel=00, rf_waddr=3, arg1=BEEF.
//  3. Round-robin: all three pending, addrs 1/2/4, rr_ptr=0 -> writes in order src0, src1, src2,
//     mux_sel 00,01,10 on 3 consecutive cycles. rr_ptr ends at 0.
//  4. Stall: src2 pending, rf_stall=1 for 4 cycles -> rf_wen=0 and entry retained.
//     Cycle after stall drops: rf_wen=1, mux_sel=10.
//  5. WAW conflict: src1 pending addr=7 under stall, req0 addr=7 -> ack0=0 until src1 drains.
//     Same cycle as the drain: ack0=1. Next cycle writes src0 to addr 7.
//  6. Throughput: src1 streams req every cycle, addrs 0..7, with others idle -> ack1=1 every cycle.
//     rf_wen=1 on 8 consecutive cycles starting one after the first ack, mux_sel=01.

Source files
------------

// File: rtl/regfile_wb_arbiter_pkg.sv
// rtl/regfile_wb_arbiter_pkg.sv - shared constants and helpers for the writeback arbiter
package regfile_wb_arbiter_pkg;

    localparam int WB_DW   = 16;
    localparam int WB_AW   = 4;
    localparam int WB_NSRC = 3;

    typedef logic [1:0] wb_sel_t;

    localparam wb_sel_t WB_SEL_SRC0 = 2'b00;
    localparam wb_sel_t WB_SEL_SRC1 = 2'b01;
    localparam wb_sel_t WB_SEL_SRC2 = 2'b10;

    // Modulo-3 increment; an out-of-range input folds back to source 0.
    function automatic wb_sel_t wrap3_inc(input wb_sel_t p);
        wrap3_inc = (p >= 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr_pick3.sv
// rtl/regfile_wb_arbiter_rr_pick3.sv - combinational 3-way round-robin picker
module regfile_wb_arbiter_rr_pick3
    import regfile_wb_arbiter_pkg::*;
(
    input  logic [2:0] valid,
    input  logic [1:0] ptr,
    input  logic       en,
    output logic [2:0] gnt,
    output logic [1:0] gidx,
    output logic       any
);

    wb_sel_t idx;

    always_comb begin
        gnt  = 3'b000;
        gidx = 2'd0;
        any  = 1'b0;
        idx  = (ptr == 2'd3) ? 2'd0 : ptr;
        for (int k = 0; k < 3; k++) begin
            if (en && !any && valid[idx]) begin
                gnt[idx] = 1'b1;
                gidx     = idx;
                any      = 1'b1;
            end
            idx = wrap3_inc(idx);
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - shares the register-file write port between three writeback sources
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int DW = WB_DW,
    parameter int AW = WB_AW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [2:0]    req,
    output logic [2:0]    ack,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [AW-1:0] addr2,
    input  logic [DW-1:0] data0,
    input  logic [DW-1:0] data1,
    input  logic [DW-1:0] data2,
    input  logic          rf_stall,
    output logic [DW-1:0] arg1,
    output logic [DW-1:0] arg2,
    output logic [DW-1:0] arg3,
    output logic [1:0]    mux_sel,
    output logic          rf_wen,
    output logic [AW-1:0] rf_waddr,
    output logic          busy
);

    logic [2:0]    hold_valid_q, hold_valid_d;
    logic [AW-1:0] hold_addr_q [WB_NSRC];
    logic [AW-1:0] hold_addr_d [WB_NSRC];
    logic [DW-1:0] hold_data_q [WB_NSRC];
    logic [DW-1:0] hold_data_d [WB_NSRC];
    wb_sel_t       rr_ptr_q, rr_ptr_d;

    logic [AW-1:0] addr_in [WB_NSRC];
    logic [DW-1:0] data_in [WB_NSRC];
    logic [2:0]    drain;
    logic [1:0]    gidx;
    logic          any;
    logic [2:0]    conflict;
    logic [2:0]    ack_c;

    assign addr_in[0] = addr0;
    assign addr_in[1] = addr1;
    assign addr_in[2] = addr2;
    assign data_in[0] = data0;
    assign data_in[1] = data1;
    assign data_in[2] = data2;

    regfile_wb_arbiter_rr_pick3 u_pick (
        .valid (hold_valid_q),
        .ptr   (rr_ptr_q),
        .en    (~rf_stall),
        .gnt   (drain),
        .gidx  (gidx),
        .any   (any)
    );

    // A request may not overtake a still-pending write to the same register,
    // nor a lower-index request to the same register accepted in the same cycle.
    always_comb begin
        conflict = 3'b000;
        ack_c    = 3'b000;
        for (int i = 0; i < WB_NSRC; i++) begin
            for (int j = 0; j < WB_NSRC; j++) begin
                if (j != i && hold_valid_q[j] && !drain[j] && hold_addr_q[j] == addr_in[i])
                    conflict[i] = 1'b1;
            end
            ack_c[i] = req[i] && (!hold_valid_q[i] || drain[i]) && !conflict[i] && !reset;
            for (int j = 0; j < i; j++) begin
                if (ack_c[j] && addr_in[j] == addr_in[i])
                    ack_c[i] = 1'b0;
            end
        end
    end

    assign ack = ack_c;

    always_comb begin
        hold_valid_d = (hold_valid_q & ~drain) | ack_c;
        for (int i = 0; i < WB_NSRC; i++) begin
            hold_addr_d[i] = ack_c[i] ? addr_in[i] : hold_addr_q[i];
            hold_data_d[i] = ack_c[i] ? data_in[i] : hold_data_q[i];
        end
        rr_ptr_d = any ? wrap3_inc(gidx) : rr_ptr_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_valid_q <= 3'b000;
            rr_ptr_q     <= 2'd0;
            for (int i = 0; i < WB_NSRC; i++) begin
                hold_addr_q[i] <= '0;
                hold_data_q[i] <= '0;
            end
        end else begin
            hold_valid_q <= hold_valid_d;
            rr_ptr_q     <= rr_ptr_d;
            for (int i = 0; i < WB_NSRC; i++) begin
                hold_addr_q[i] <= hold_addr_d[i];
                hold_data_q[i] <= hold_data_d[i];
            end
        end
    end

    always_comb begin
        rf_wen   = any;
        mux_sel  = WB_SEL_SRC0;
        rf_waddr = '0;
        if (any) begin
            case (gidx)
                2'd1:    begin mux_sel = WB_SEL_SRC1; rf_waddr = hold_addr_q[1]; end
                2'd2:    begin mux_sel = WB_SEL_SRC2; rf_waddr = hold_addr_q[2]; end
                default: begin mux_sel = WB_SEL_SRC0; rf_waddr = hold_addr_q[0]; end
            endcase
        end
    end

    assign arg1 = hold_data_q[0];
    assign arg2 = hold_data_q[1];
    assign arg3 = hold_data_q[2];
    assign busy = |hold_valid_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - scoreboard bench for the writeback arbiter
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  req;
    logic [2:0]  ack;
    logic [3:0]  addr0, addr1, addr2;
    logic [15:0] data0, data1, data2;
    logic        rf_stall;
    logic [15:0] arg1, arg2, arg3;
    logic [1:0]  mux_sel;
    logic        rf_wen;
    logic [3:0]  rf_waddr;
    logic        busy;

    typedef struct {
        logic [1:0]  sel;
        logic [3:0]  addr;
        logic [15:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  n_chk  = 0;
    int  n_fail = 0;

    regfile_wb_arbiter dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .ack      (ack),
        .addr0    (addr0),
        .addr1    (addr1),
        .addr2    (addr2),
        .data0    (data0),
        .data1    (data1),
        .data2    (data2),
        .rf_stall (rf_stall),
        .arg1     (arg1),
        .arg2     (arg2),
        .arg3     (arg3),
        .mux_sel  (mux_sel),
        .rf_wen   (rf_wen),
        .rf_waddr (rf_waddr),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] sel, input logic [3:0] a, input logic [15:0] d);
        wr_t e;
        e.sel  = sel;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Monitor: every register-file write must match the next expected write.
    always @(negedge clk) begin
        if (!reset) begin
            if (rf_wen) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", {28'd0, rf_waddr}, 32'hFFFF_FFFF);
                end else begin
                    wr_t e;
                    logic [15:0] d;
                    e = exp_q.pop_front();
                    d = (mux_sel == 2'b00) ? arg1 : (mux_sel == 2'b01) ? arg2 :
                        (mux_sel == 2'b10) ? arg3 : 16'hxxxx;
                    chk("wr_sel",  {30'd0, mux_sel}, {30'd0, e.sel});
                    chk("wr_addr", {28'd0, rf_waddr}, {28'd0, e.addr});
                    chk("wr_data", {16'd0, d}, {16'd0, e.data});
                end
            end else begin
                chk("idle_decode", {26'd0, mux_sel, rf_waddr}, 32'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; req = 3'b000; rf_stall = 1'b0;
        addr0 = 4'd1; addr1 = 4'd2; addr2 = 4'd4;
        data0 = 16'h0; data1 = 16'h0; data2 = 16'h0;
        cyc(); cyc();

        // Reset state, with requests asserted
        req = 3'b111;
        @(negedge clk);
        chk("rst_ack", {29'd0, ack}, 32'd0);
        chk("rst_wen", {31'd0, rf_wen}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_sel", {30'd0, mux_sel}, 32'd0);
        chk("rst_waddr", {28'd0, rf_waddr}, 32'd0);
        chk("rst_arg", {arg1, arg2 | arg3}, 32'd0);
        req = 3'b000;
        cyc();
        reset = 1'b0;

        // Single write from src0
        req = 3'b001; addr0 = 4'd3; data0 = 16'hBEEF;
        @(negedge clk);
        chk("single_ack", {29'd0, ack}, 32'b001);
        push(2'b00, 4'd3, 16'hBEEF);
        cyc(); req = 3'b000;
        @(negedge clk);
        chk("single_wen", {31'd0, rf_wen}, 32'd1);
        chk("single_waddr", {28'd0, rf_waddr}, 32'd3);
        chk("single_arg1", {16'd0, arg1}, 32'hBEEF);
        cyc();

        // Stall holds src2 for four cycles
        rf_stall = 1'b1;
        req = 3'b100; addr2 = 4'd9; data2 = 16'h4444;
        @(negedge clk);
        chk("stall_ack", {29'd0, ack}, 32'b100);
        push(2'b10, 4'd9, 16'h4444);
        cyc(); req = 3'b000;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("stall_wen", {31'd0, rf_wen}, 32'd0);
            chk("stall_busy", {31'd0, busy}, 32'd1);
            cyc();
        end
        rf_stall = 1'b0;
        @(negedge clk);
        chk("unstall_wen", {31'd0, rf_wen}, 32'd1);
        chk("unstall_sel", {30'd0, mux_sel}, 32'b10);
        cyc();

        // Round-robin over three pending entries from rr_ptr=0
        req = 3'b111;
        addr0 = 4'd1; addr1 = 4'd2; addr2 = 4'd4;
        data0 = 16'h1111; data1 = 16'h2222; data2 = 16'h3333;
        @(negedge clk);
        chk("rr_ack", {29'd0, ack}, 32'b111);
        push(2'b00, 4'd1, 16'h1111);
        push(2'b01, 4'd2, 16'h2222);
        push(2'b10, 4'd4, 16'h3333);
        cyc(); req = 3'b000;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rr_wen", {31'd0, rf_wen}, 32'd1);
            chk("rr_sel", {30'd0, mux_sel}, k);
            cyc();
        end

        // rr_ptr back at 0: src0 wins over src2
        req = 3'b101; addr0 = 4'd6; data0 = 16'h5555; addr2 = 4'd8; data2 = 16'h6666;
        @(negedge clk);
        chk("ptr_ack", {29'd0, ack}, 32'b101);
        push(2'b00, 4'd6, 16'h5555);
        push(2'b10, 4'd8, 16'h6666);
        cyc(); req = 3'b000;
        @(negedge clk);
        chk("ptr_first", {30'd0, mux_sel}, 32'b00);
        cyc();
        @(negedge clk);
        chk("ptr_second", {30'd0, mux_sel}, 32'b10);
        cyc();

        // Same address from two idle sources: lowest index only
        req = 3'b101; addr0 = 4'd5; data0 = 16'h7777; addr2 = 4'd5; data2 = 16'h8888;
        @(negedge clk);
        chk("same_addr_ack", {29'd0, ack}, 32'b001);
        push(2'b00, 4'd5, 16'h7777);
        cyc(); req = 3'b100;
        @(negedge clk);
        chk("same_addr_ack2", {29'd0, ack}, 32'b100);
        push(2'b10, 4'd5, 16'h8888);
        cyc(); req = 3'b000;
        @(negedge clk);
        cyc();

        // WAW: src0 blocked behind pending src1 to the same register
        rf_stall = 1'b1;
        req = 3'b010; addr1 = 4'd7; data1 = 16'hAAAA;
        @(negedge clk);
        chk("waw_ack1", {29'd0, ack}, 32'b010);
        push(2'b01, 4'd7, 16'hAAAA);
        cyc(); req = 3'b001; addr0 = 4'd7; data0 = 16'hBBBB;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("waw_blocked", {29'd0, ack}, 32'b000);
            cyc();
        end
        rf_stall = 1'b0;
        @(negedge clk);
        chk("waw_release", {29'd0, ack}, 32'b001);
        chk("waw_drain_sel", {30'd0, mux_sel}, 32'b01);
        push(2'b00, 4'd7, 16'hBBBB);
        cyc(); req = 3'b000;
        @(negedge clk);
        chk("waw_wen", {31'd0, rf_wen}, 32'd1);
        chk("waw_waddr", {28'd0, rf_waddr}, 32'd7);
        cyc();

        // Back-to-back stream from src1
        for (int k = 0; k < 8; k++) begin
            req = 3'b010; addr1 = 4'(k); data1 = 16'hC000 + 16'(k);
            @(negedge clk);
            chk("stream_ack", {29'd0, ack}, 32'b010);
            push(2'b01, 4'(k), 16'hC000 + 16'(k));
            if (k > 0) begin
                chk("stream_wen", {31'd0, rf_wen}, 32'd1);
                chk("stream_sel", {30'd0, mux_sel}, 32'b01);
            end
            cyc();
        end
        req = 3'b000;
        @(negedge clk);
        chk("stream_last_wen", {31'd0, rf_wen}, 32'd1);
        cyc();

        // Mid-cycle reset discards a pending src1 entry
        rf_stall = 1'b1;
        req = 3'b010; addr1 = 4'd3; data1 = 16'hDEAD;
        @(negedge clk);
        chk("mrst_ack", {29'd0, ack}, 32'b010);
        cyc(); addr1 = 4'd2;
        #2 reset = 1'b1;
        #1;
        chk("mrst_wen", {31'd0, rf_wen}, 32'd0);
        chk("mrst_busy", {31'd0, busy}, 32'd0);
        chk("mrst_ack0", {29'd0, ack}, 32'd0);
        req = 3'b000;
        cyc();
        reset = 1'b0; rf_stall = 1'b0;
        for (int k = 0; k < 5; k++) cyc();
        @(negedge clk);
        chk("mrst_busy_after", {31'd0, busy}, 32'd0);
        chk("queue_empty", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
